// File: rtl/mem_responder.sv
// mem_responder: word-organised memory target with a valid/ready request port,
// a fixed number of wait states and a registered response. Stores are byte-lane
// writable. A request is committed on the same edge that moves the FSM into RESP.
module mem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    ReqValid,
    output logic                    ReqReady,
    input  logic                    ReqWrite,
    input  logic [31:0]             ReqAddr,
    input  logic [DATA_WIDTH-1:0]   ReqWData,
    input  logic [DATA_WIDTH/8-1:0] ReqByteEn,
    output logic                    RspValid,
    input  logic                    RspReady,
    output logic [DATA_WIDTH-1:0]   RspRData,
    output logic                    RspError
);

    localparam int         LANES     = DATA_WIDTH / 8;
    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    commit;

    // Latched request
    logic                    wr_q;
    logic [31:0]             addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [LANES-1:0]        be_q;

    // Registered response
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;

    // Storage
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // The request being committed: with zero wait states it is committed on its
    // acceptance edge, so it comes straight from the ports rather than the latch.
    logic                    eff_write;
    logic [31:0]             eff_addr;
    logic [DATA_WIDTH-1:0]   eff_wdata;
    logic [LANES-1:0]        eff_be;
    logic                    eff_err;
    logic [ADDR_WIDTH-1:0]   eff_idx;

    assign eff_write = (state_q == IDLE) ? ReqWrite  : wr_q;
    assign eff_addr  = (state_q == IDLE) ? ReqAddr   : addr_q;
    assign eff_wdata = (state_q == IDLE) ? ReqWData  : wdata_q;
    assign eff_be    = (state_q == IDLE) ? ReqByteEn : be_q;
    assign eff_err   = (eff_addr[1:0] != 2'b00) || ((eff_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign eff_idx   = eff_addr[ADDR_WIDTH+1:2];

    assign ReqReady  = (state_q == IDLE);
    assign RspValid  = rsp_valid_q;
    assign RspRData  = rdata_q;
    assign RspError  = err_q;

    // Next-state, wait counter and commit strobe.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    if (WAIT_LOAD == 4'd0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP: begin
                if (RspReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state is always assigned with <= so every register
        // samples the pre-edge values regardless of statement order.
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request on acceptance so the requester may change its inputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if ((state_q == IDLE) && ReqValid) begin
            wr_q    <= ReqWrite;
            addr_q  <= ReqAddr;
            wdata_q <= ReqWData;
            be_q    <= ReqByteEn;
        end
    end

    // Response registers: loaded on commit, held through RESP, cleared on completion.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= (state_d == RESP);
            if (commit) begin
                err_q   <= eff_err;
                rdata_q <= (eff_err || eff_write) ? '0 : mem[eff_idx];
            end else if ((state_q == RESP) && RspReady) begin
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    // Byte-lane store on commit; a reset on the commit edge discards the write.
    always_ff @(posedge CLK) begin
        // NOTE: the array has no reset branch; contents survive reset and are
        // undefined until written, which keeps it mappable onto block RAM.
        if (!RST && commit && eff_write && !eff_err) begin
            for (int i = 0; i < LANES; i++) begin
                if (eff_be[i]) begin
                    mem[eff_idx][8*i +: 8] <= eff_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: a 2-wait-state instance (index 0) and a
// zero-wait-state instance (index 1) checked against a byte-addressed model.
module tb_mem_responder;

    localparam int AW  = 10;
    localparam int W_A = 2;
    localparam int W_B = 0;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_error [2];

    int checks   = 0;
    int failures = 0;

    // Reference memory, one byte per byte address.
    logic [7:0] model_mem [2][4096];

    mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .WAIT_CYCLES(W_A)) u_dut_a (
        .CLK(clk), .RST(rst[0]),
        .ReqValid(req_valid[0]), .ReqReady(req_ready[0]), .ReqWrite(req_write[0]),
        .ReqAddr(req_addr[0]), .ReqWData(req_wdata[0]), .ReqByteEn(req_be[0]),
        .RspValid(rsp_valid[0]), .RspReady(rsp_ready[0]),
        .RspRData(rsp_rdata[0]), .RspError(rsp_error[0])
    );

    mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .WAIT_CYCLES(W_B)) u_dut_b (
        .CLK(clk), .RST(rst[1]),
        .ReqValid(req_valid[1]), .ReqReady(req_ready[1]), .ReqWrite(req_write[1]),
        .ReqAddr(req_addr[1]), .ReqWData(req_wdata[1]), .ReqByteEn(req_be[1]),
        .RspValid(rsp_valid[1]), .RspReady(rsp_ready[1]),
        .RspRData(rsp_rdata[1]), .RspError(rsp_error[1])
    );

    function automatic int exp_latency(input int d);
        return (d == 0) ? W_A + 1 : W_B + 1;
    endfunction

    function automatic bit model_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'(4 * (1 << AW)));
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
        int b;
        b = int'(a);
        return {model_mem[d][b+3], model_mem[d][b+2], model_mem[d][b+1], model_mem[d][b]};
    endfunction

    task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] be);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) model_mem[d][int'(a) + i] = wd[8*i +: 8];
        end
    endtask

    // One complete transaction with RspReady raised once the response appears;
    // checks handshake, latency and response against the model.
    task automatic run_txn(input int d, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, input string tag,
                           output logic [31:0] got_data, output logic got_err);
        logic [31:0] exp_data;
        bit          exp_err;
        int          n;
        int          lat;
        exp_err  = model_err(addr);
        exp_data = (wr || exp_err) ? 32'd0 : model_read(d, addr);
        if (wr && !exp_err) model_write(d, addr, wdata, be);

        n = 0;
        while (req_ready[d] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (req_ready[d] !== 1'b1) $display("FAIL %s ready: got %b expected 1", tag, req_ready[d]);

        req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = addr;
        req_wdata[d] = wdata; req_be[d] = be;
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_write[d] = 1'($urandom); req_addr[d] = $urandom;
        req_wdata[d] = $urandom;     req_be[d]   = 4'($urandom);

        lat = 1;
        while (rsp_valid[d] !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
        checks++;
        if (lat != exp_latency(d)) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d", tag, lat, exp_latency(d));
        end
        checks++;
        if (rsp_rdata[d] !== exp_data) begin
            failures++;
            $display("FAIL %s rdata: got %h expected %h", tag, rsp_rdata[d], exp_data);
        end
        checks++;
        if (rsp_error[d] !== exp_err) begin
            failures++;
            $display("FAIL %s error: got %b expected %b", tag, rsp_error[d], exp_err);
        end
        got_data = rsp_rdata[d];
        got_err  = rsp_error[d];

        rsp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        checks++;
        if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            failures++;
            $display("FAIL %s complete: got valid=%b ready=%b expected valid=0 ready=1",
                     tag, rsp_valid[d], req_ready[d]);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0; req_be[d] = '0; rsp_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 ||
                rsp_rdata[d] !== 32'd0 || rsp_error[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset dut%0d: got ready=%b valid=%b rdata=%h err=%b expected 1 0 0 0",
                         d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_error[d]);
            end
            rst[d] = 1'b0;
        end
        @(negedge clk);
    endtask

    // Give the window of words used later a defined value in both instances.
    task automatic test_init();
        logic [31:0] gd;
        logic        ge;
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++) begin
                run_txn(d, 1'b1, 32'(4 * w), $urandom, 4'hF, "init", gd, ge);
            end
        end
    endtask

    task automatic test_write_read();
        logic [31:0] gd;
        logic        ge;
        run_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr_full", gd, ge);
        checks++;
        if (gd !== 32'd0) begin
            failures++; $display("FAIL wr_full resp data: got %h expected 00000000", gd);
        end
        run_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, "rd_full", gd, ge);
        checks++;
        if (gd !== 32'hDEADBEEF || ge !== 1'b0) begin
            failures++; $display("FAIL rd_full: got %h/%b expected deadbeef/0", gd, ge);
        end
    endtask

    task automatic test_byte_lane();
        logic [31:0] gd;
        logic        ge;
        run_txn(0, 1'b1, 32'h10, 32'h0000AB00, 4'b0010, "wr_lane", gd, ge);
        run_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, "rd_lane", gd, ge);
        checks++;
        if (gd !== 32'hDEADABEF) begin
            failures++; $display("FAIL rd_lane: got %h expected deadabef", gd);
        end
        run_txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, "wr_none", gd, ge);
        checks++;
        if (ge !== 1'b0) begin
            failures++; $display("FAIL wr_none error: got %b expected 0", ge);
        end
        run_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, "rd_none", gd, ge);
        checks++;
        if (gd !== 32'hDEADABEF) begin
            failures++; $display("FAIL rd_none: got %h expected deadabef", gd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] gd;
        logic [31:0] word0;
        logic        ge;
        run_txn(0, 1'b0, 32'h13, 32'h0, 4'h0, "rd_misaligned", gd, ge);
        checks++;
        if (ge !== 1'b1 || gd !== 32'd0) begin
            failures++; $display("FAIL rd_misaligned: got %h/%b expected 00000000/1", gd, ge);
        end
        word0 = model_read(0, 32'h0);
        run_txn(0, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, "wr_range", gd, ge);
        checks++;
        if (ge !== 1'b1) begin
            failures++; $display("FAIL wr_range error: got %b expected 1", ge);
        end
        run_txn(0, 1'b0, 32'h0, 32'h0, 4'h0, "rd_word0", gd, ge);
        checks++;
        if (gd !== word0) begin
            failures++; $display("FAIL rd_word0: got %h expected %h", gd, word0);
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] exp0, exp1;
        int          n;
        exp0 = model_read(0, 32'h10);
        exp1 = model_read(0, 32'h14);
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h10;
        @(posedge clk);
        @(negedge clk);
        req_addr[0] = 32'h14;
        n = 0;
        while (rsp_valid[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (rsp_rdata[0] !== exp0) begin
            failures++; $display("FAIL bp first data: got %h expected %h", rsp_rdata[0], exp0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid[0] !== 1'b1 || req_ready[0] !== 1'b0 || rsp_rdata[0] !== exp0) begin
                failures++;
                $display("FAIL bp hold %0d: got valid=%b ready=%b rdata=%h expected 1 0 %h",
                         i, rsp_valid[0], req_ready[0], rsp_rdata[0], exp0);
            end
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL bp release: got valid=%b ready=%b expected 0 1", rsp_valid[0], req_ready[0]);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        checks++;
        if (req_ready[0] !== 1'b0) begin
            failures++; $display("FAIL bp second accept: got ready=%b expected 0", req_ready[0]);
        end
        n = 1;
        while (rsp_valid[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (n != exp_latency(0)) begin
            failures++; $display("FAIL bp second latency: got %0d expected %0d", n, exp_latency(0));
        end
        checks++;
        if (rsp_rdata[0] !== exp1) begin
            failures++; $display("FAIL bp second data: got %h expected %h", rsp_rdata[0], exp1);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] gd;
        logic        ge;
        int          n;
        run_txn(0, 1'b1, 32'h20, 32'h0, 4'hF, "wr_zero", gd, ge);
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h20;
        req_wdata[0] = 32'h12345678; req_be[0] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        rst[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        checks++;
        if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 ||
            rsp_rdata[0] !== 32'd0 || rsp_error[0] !== 1'b0) begin
            failures++;
            $display("FAIL mid_wait reset: got ready=%b valid=%b rdata=%h err=%b expected 1 0 0 0",
                     req_ready[0], rsp_valid[0], rsp_rdata[0], rsp_error[0]);
        end
        run_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, "rd_after_reset", gd, ge);
        checks++;
        if (gd !== 32'd0) begin
            failures++; $display("FAIL rd_after_reset: got %h expected 00000000", gd);
        end
    endtask

    task automatic test_random();
        logic [31:0] gd;
        logic [31:0] addr;
        logic        ge;
        int          kind;
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 7));
            if (kind == 0)      addr = 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
            else if (kind == 1) addr = {$urandom_range(1, 1048575), 12'h0} + 32'(4 * $urandom_range(0, 15));
            else                addr = 32'(4 * $urandom_range(0, 15));
            run_txn(0, 1'($urandom), addr, $urandom, 4'($urandom), "random", gd, ge);
        end
    endtask

    // Zero-wait instance with request and response held valid/ready: one
    // acceptance every other cycle, each answered on the very next cycle.
    task automatic test_back_to_back();
        logic [31:0] pend[$];
        logic [31:0] a, exp;
        int          acc, rsp;
        bit          took;
        acc = 0; rsp = 0;
        req_valid[1] = 1'b1; req_write[1] = 1'b0; rsp_ready[1] = 1'b1;
        req_addr[1]  = 32'(4 * $urandom_range(0, 15));
        for (int c = 0; c < 12; c++) begin
            took = (req_ready[1] === 1'b1);
            if (took) begin pend.push_back(req_addr[1]); acc++; end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (rsp_valid[1] !== took) begin
                failures++;
                $display("FAIL b2b valid cycle %0d: got %b expected %b", c, rsp_valid[1], took);
            end
            if (rsp_valid[1] === 1'b1 && pend.size() > 0) begin
                rsp++;
                a   = pend.pop_front();
                exp = model_read(1, a);
                checks++;
                if (rsp_rdata[1] !== exp) begin
                    failures++;
                    $display("FAIL b2b data cycle %0d: got %h expected %h", c, rsp_rdata[1], exp);
                end
            end
            if (took) req_addr[1] = 32'(4 * $urandom_range(0, 15));
        end
        req_valid[1] = 1'b0; rsp_ready[1] = 1'b0;
        checks++;
        if (acc != 6 || rsp != 6) begin
            failures++; $display("FAIL b2b counts: got acc=%0d rsp=%0d expected 6 6", acc, rsp);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_byte_lane();
        test_errors();
        test_back_pressure();
        test_reset_mid_wait();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-organised memory responder for the multicycle processor: the target end of the memory request/response interface driven by the control FSM during instruction fetch, load and store. It accepts one request at a time over a valid/ready handshake, inserts a fixed number of wait states, then returns a registered response. The datapath captures that response into its holding registers. Storage is byte-lane writable; the read/write bus width is one word.

## Interface
- DATA_WIDTH, 32, word width in bits; must be 32 (4 byte lanes)
- ADDR_WIDTH, 10, word-index width; memory depth = 2^ADDR_WIDTH words
- WAIT_CYCLES, 2, wait states between request acceptance and response (0..15)

- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- ReqValid  in  1  request present
- ReqReady  out  1  responder can accept a request
- ReqWrite  in  1  1 = store, 0 = load/fetch
- ReqAddr  in  32  byte address
- ReqWData  in  32  store data
- ReqByteEn  in  4  store byte-lane enables; bit i covers bits [8i+7:8i]
- RspValid  out  1  response present
- RspReady  in  1  requester accepts response
- RspRData  out  32  load data; 0 for stores and errors
- RspError  out  1  request was misaligned or out of range

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - ReqReady = 1.
  - On ReqValid=1, the request is accepted. ReqWrite, ReqAddr, ReqWData and ReqByteEn are latched internally; the inputs may change afterwards.
  - Next state is WAIT if WAIT_CYCLES > 0, otherwise RESP.
- WAIT:
  - ReqReady = 0.
  - A down-counter is loaded with WAIT_CYCLES at acceptance and decrements once per WAIT cycle.
  - When the counter reaches its last count, the next state is RESP.
- Transition into RESP (same edge for every path):
  - Error check: the latched address is in error if addr[1:0] != 0 (misaligned) or addr[31:ADDR_WIDTH+2] != 0 (out of range).
  - Error: RspError <= 1, RspRData <= 0, memory unchanged.
  - Read without error: RspRData <= mem[addr[ADDR_WIDTH+1:2]].
  - Write without error: each lane with ByteEn=1 is written from WData; other lanes keep their value. RspRData <= 0. ByteEn = 0000 is legal, writes nothing, and returns no error.
- RESP:
  - RspValid = 1.
  - RspRData and RspError are held stable until RspReady=1.
  - On RspReady=1 the response completes and the next state is IDLE.
  - ReqReady = 0; no request is accepted in RESP.
- Memory contents are not cleared by reset. They are undefined until written.

## Timing
- Reset values: ReqReady=1 (IDLE), RspValid=0, RspRData=0, RspError=0. The wait counter is 0.
- Reset is taken at any point, including WAIT or RESP:
  - The next state is IDLE and outputs take their reset values.
  - A write that has not yet reached the RESP transition is discarded.
  - A write already committed stays in memory.
- Latency: a request accepted at edge t has RspValid=1 during cycle t+WAIT_CYCLES+1.
- Minimum transaction period: WAIT_CYCLES+2 cycles, with RspReady held high. The IDLE cycle after RESP is mandatory.
- Outputs are registered (no combinational path from input to output), except ReqReady, which is decoded from state only.
- Back-pressure: RspReady low holds RESP indefinitely; no new request is accepted.
- Read-after-write to the same word in consecutive transactions returns the new data. No bypass is needed because the write commits before the read is accepted.

## Test plan
- Reset, then write 0xDEADBEEF to 0x10 with ByteEn=1111, then read 0x10 -> RspValid rises 3 cycles after each acceptance (WAIT_CYCLES=2); read returns 0xDEADBEEF with RspError=0; write response has RspRData=0.
- Byte-lane write: 0x0000AB00 to 0x10 with ByteEn=0010 over 0xDEADBEEF, then read -> 0xDEADABEF.
- Errors: read at 0x13 -> RspError=1, RspRData=0; write at 0x1000 (ADDR_WIDTH=10) -> RspError=1, and a read of word 0 is unchanged.
- Back-pressure: hold RspReady=0 for 5 cycles in RESP while ReqValid=1 -> RspRData stable, ReqReady=0, no second acceptance. Release -> IDLE next cycle, then the new request is accepted.
- Reset mid-WAIT on a write of 0x12345678 to 0x20, after first writing 0 there -> outputs return to reset values next cycle; a subsequent read of 0x20 returns 0.
- WAIT_CYCLES=0 build: back-to-back reads with RspReady=1 -> RspValid one cycle after acceptance; a request is accepted every 2 cycles.
